decrypt_stream_arbiter: RTL and testbench

//  Shares one configurable decrypt unit between two byte-stream requesters at frame granularity.

---
 rtl/decrypt_stream_arbiter.sv | 138 +++++++++++++
 tb/tb_decrypt_stream_arbiter.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decrypt_stream_arbiter.sv
// Frame-granular arbiter sharing one decrypt unit between two byte-stream channels.
// Loads the owner's key set and restarts the unit's key rotation before every frame.
module decrypt_stream_arbiter #(
    parameter int PIPE_LAT = 2,
    parameter int CNT_W    = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cfg_we,
    input  logic        cfg_ch,
    input  logic [23:0] cfg_key,
    input  logic        req0_valid,
    input  logic [7:0]  req0_data,
    input  logic        req0_last,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [7:0]  req1_data,
    input  logic        req1_last,
    output logic        req1_ready,
    output logic        unit_rst_n,
    output logic        unit_en,
    output logic [7:0]  unit_din,
    output logic [23:0] unit_key,
    input  logic        unit_v,
    input  logic [7:0]  unit_dout,
    output logic        out0_v,
    output logic [7:0]  out0_data,
    output logic        out1_v,
    output logic [7:0]  out1_data,
    output logic        grant_ch,
    output logic        busy
);

    typedef enum logic [2:0] {
        IDLE,
        FLUSH,
        LOAD,
        STREAM,
        DRAIN
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [23:0]        key0;
    logic [23:0]        key1;
    logic               rr_prio;
    logic [CNT_W-1:0]   cnt;

    logic               any_valid;
    logic               owner;
    logic               sel_valid;
    logic [7:0]         sel_data;
    logic               sel_last;
    logic               accept;
    logic               accept_last;

    // Round-robin only matters when both channels ask in the same IDLE cycle.
    assign any_valid   = req0_valid | req1_valid;
    assign owner       = (req0_valid & req1_valid) ? rr_prio : req1_valid;

    assign sel_valid   = grant_ch ? req1_valid : req0_valid;
    assign sel_data    = grant_ch ? req1_data  : req0_data;
    assign sel_last    = grant_ch ? req1_last  : req0_last;
    assign accept      = (state == STREAM) & sel_valid;
    assign accept_last = accept & sel_last;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_valid) state_nxt = FLUSH;
            FLUSH:   state_nxt = LOAD;
            LOAD:    state_nxt = STREAM;
            STREAM:  if (accept_last) state_nxt = DRAIN;
            DRAIN:   if (cnt <= CNT_W'(1)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            key0     <= '0;
            key1     <= '0;
            unit_key <= '0;
            grant_ch <= 1'b0;
            rr_prio  <= 1'b0;
            cnt      <= '0;
        end else begin
            state <= state_nxt;
            if (cfg_we) begin
                if (cfg_ch) key1 <= cfg_key;
                else        key0 <= cfg_key;
            end
            // Shadow key is frozen for the whole frame; later cfg writes wait for the next grant.
            if (state == IDLE && any_valid) begin
                grant_ch <= owner;
                unit_key <= owner ? key1 : key0;
            end
            if (accept_last) begin
                cnt     <= CNT_W'(PIPE_LAT);
                rr_prio <= ~grant_ch;
            end else if (state == DRAIN) begin
                cnt <= cnt - CNT_W'(1);
            end
        end
    end

    // The unit is also held in reset while rst is asserted, not only during FLUSH.
    assign unit_rst_n = ~rst & (state != FLUSH);
    assign busy       = (state != IDLE);

    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        unit_en    = 1'b0;
        unit_din   = '0;
        out0_v     = 1'b0;
        out0_data  = '0;
        out1_v     = 1'b0;
        out1_data  = '0;
        if (state == STREAM) begin
            req0_ready = ~grant_ch;
            req1_ready = grant_ch;
            unit_en    = sel_valid;
            unit_din   = sel_data;
        end
        if (state == STREAM || state == DRAIN) begin
            if (grant_ch) begin
                out1_v    = unit_v;
                out1_data = unit_dout;
            end else begin
                out0_v    = unit_v;
                out0_data = unit_dout;
            end
        end
    end

endmodule

// File: tb/tb_decrypt_stream_arbiter.sv
// Bench for decrypt_stream_arbiter: per-cycle vector table plus directed multi-cycle sequences,
// with a two-stage decrypt-unit stand-in that inverts each byte.
module tb_decrypt_stream_arbiter;

    logic        clk;
    logic        rst;
    logic        cfg_we;
    logic        cfg_ch;
    logic [23:0] cfg_key;
    logic        req0_valid;
    logic [7:0]  req0_data;
    logic        req0_last;
    logic        req0_ready;
    logic        req1_valid;
    logic [7:0]  req1_data;
    logic        req1_last;
    logic        req1_ready;
    logic        unit_rst_n;
    logic        unit_en;
    logic [7:0]  unit_din;
    logic [23:0] unit_key;
    logic        unit_v;
    logic [7:0]  unit_dout;
    logic        out0_v;
    logic [7:0]  out0_data;
    logic        out1_v;
    logic [7:0]  out1_data;
    logic        grant_ch;
    logic        busy;

    decrypt_stream_arbiter #(.PIPE_LAT(2), .CNT_W(3)) dut (
        .clk(clk), .rst(rst),
        .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_key(cfg_key),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_last(req0_last), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_last(req1_last), .req1_ready(req1_ready),
        .unit_rst_n(unit_rst_n), .unit_en(unit_en), .unit_din(unit_din), .unit_key(unit_key),
        .unit_v(unit_v), .unit_dout(unit_dout),
        .out0_v(out0_v), .out0_data(out0_data), .out1_v(out1_v), .out1_data(out1_data),
        .grant_ch(grant_ch), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Decrypt unit stand-in: latency 2, plaintext = ~ciphertext, pipeline cleared by unit_rst_n.
    logic       v1, v2;
    logic [7:0] d1, d2;
    always_ff @(posedge clk) begin
        if (!unit_rst_n) begin
            v1 <= 1'b0; v2 <= 1'b0; d1 <= 8'h00; d2 <= 8'h00;
        end else begin
            v1 <= unit_en;
            d1 <= unit_en ? ~unit_din : 8'h00;
            v2 <= v1;
            d2 <= d1;
        end
    end
    assign unit_v    = v2;
    assign unit_dout = d2;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Monitor: acceptances and plaintext per channel, ignoring cycles with rst high.
    logic [8:0] acc_log[$];
    logic [7:0] o0_log[$];
    logic [7:0] o1_log[$];
    int         both_rdy = 0;
    always @(negedge clk) begin
        #2;
        if (!rst) begin
            if (req0_valid && req0_ready) acc_log.push_back({1'b0, req0_data});
            if (req1_valid && req1_ready) acc_log.push_back({1'b1, req1_data});
            if (out0_v) o0_log.push_back(out0_data);
            if (out1_v) o1_log.push_back(out1_data);
            if (req0_ready && req1_ready) both_rdy++;
        end
    end

    typedef struct packed {
        logic        busy, urn, rdy0, rdy1, en;
        logic [7:0]  din;
        logic [23:0] ukey;
        logic        o0v;
        logic [7:0]  o0d;
        logic        o1v;
        logic [7:0]  o1d;
        logic        grant;
    } obs_t;

    typedef struct packed {
        logic        we;
        logic [23:0] key;
        logic        v0;
        logic [7:0]  d0;
        logic        l0;
        obs_t        exp;
    } vec_t;

    function automatic obs_t ob(input logic b, input logic u, input logic r, input logic e,
                                input logic [7:0] din, input logic [23:0] k,
                                input logic ov, input logic [7:0] od);
        obs_t o;
        o = {b, u, r, 1'b0, e, din, k, ov, od, 1'b0, 8'h00, 1'b0};
        return o;
    endfunction

    task automatic drive(input bit ch, input logic v, input logic [7:0] d, input logic l);
        if (ch) begin req1_valid = v; req1_data = d; req1_last = l; end
        else    begin req0_valid = v; req0_data = d; req0_last = l; end
    endtask

    // Called at a falling edge; holds the byte until it is readied, returns at the next falling edge.
    task automatic send(input bit ch, input logic [7:0] d, input logic l);
        int w;
        bit rdy;
        w = 0;
        drive(ch, 1'b1, d, l);
        #1;
        rdy = ch ? req1_ready : req0_ready;
        while (!rdy && w < 60) begin
            @(negedge clk);
            drive(ch, 1'b1, d, l);
            #1;
            rdy = ch ? req1_ready : req0_ready;
            w++;
        end
        if (!rdy) begin
            n_chk++;
            $display("FAIL send_timeout ch%0d byte %0h: ready never seen, expected ready within 60 cycles", ch, d);
        end
        @(negedge clk);
    endtask

    task automatic send_frame(input bit ch, input logic [7:0] base, input int n);
        for (int i = 0; i < n; i++) send(ch, base + 8'(i), (i == n - 1));
        drive(ch, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic wait_idle();
        int w;
        w = 0;
        #1;
        while (busy && w < 40) begin
            @(negedge clk);
            #1;
            w++;
        end
        if (busy) begin
            n_chk++;
            $display("FAIL idle_timeout: busy=1 after 40 cycles, expected 0");
        end
    endtask

    vec_t       tbl[11];
    obs_t       act;
    logic [8:0] exp_acc[$];
    logic [7:0] exp_o0[$];
    logic [7:0] exp_o1[$];

    initial begin
        tbl[0]  = {1'b1, 24'hA53C0F, 1'b0, 8'h00, 1'b0, ob(0, 1, 0, 0, 8'h00, 24'h000000, 0, 8'h00)};
        tbl[1]  = {1'b0, 24'h000000, 1'b1, 8'h10, 1'b0, ob(0, 1, 0, 0, 8'h00, 24'h000000, 0, 8'h00)};
        tbl[2]  = {1'b0, 24'h000000, 1'b1, 8'h10, 1'b0, ob(1, 0, 0, 0, 8'h00, 24'hA53C0F, 0, 8'h00)};
        tbl[3]  = {1'b0, 24'h000000, 1'b1, 8'h10, 1'b0, ob(1, 1, 0, 0, 8'h00, 24'hA53C0F, 0, 8'h00)};
        tbl[4]  = {1'b0, 24'h000000, 1'b1, 8'h10, 1'b0, ob(1, 1, 1, 1, 8'h10, 24'hA53C0F, 0, 8'h00)};
        tbl[5]  = {1'b0, 24'h000000, 1'b1, 8'h11, 1'b0, ob(1, 1, 1, 1, 8'h11, 24'hA53C0F, 0, 8'h00)};
        tbl[6]  = {1'b0, 24'h000000, 1'b1, 8'h12, 1'b0, ob(1, 1, 1, 1, 8'h12, 24'hA53C0F, 1, 8'hEF)};
        tbl[7]  = {1'b0, 24'h000000, 1'b1, 8'h13, 1'b1, ob(1, 1, 1, 1, 8'h13, 24'hA53C0F, 1, 8'hEE)};
        tbl[8]  = {1'b0, 24'h000000, 1'b0, 8'h00, 1'b0, ob(1, 1, 0, 0, 8'h00, 24'hA53C0F, 1, 8'hED)};
        tbl[9]  = {1'b0, 24'h000000, 1'b0, 8'h00, 1'b0, ob(1, 1, 0, 0, 8'h00, 24'hA53C0F, 1, 8'hEC)};
        tbl[10] = {1'b0, 24'h000000, 1'b0, 8'h00, 1'b0, ob(0, 1, 0, 0, 8'h00, 24'hA53C0F, 0, 8'h00)};

        exp_acc = '{9'h010, 9'h011, 9'h012, 9'h013,
                    9'h020, 9'h021, 9'h130, 9'h131, 9'h040, 9'h150,
                    9'h060, 9'h061, 9'h062, 9'h064,
                    9'h170, 9'h171, 9'h172, 9'h173,
                    9'h080, 9'h090, 9'h091, 9'h0A0};
        exp_o0  = '{8'hEF, 8'hEE, 8'hED, 8'hEC, 8'hDF, 8'hDE, 8'hBF,
                    8'h9F, 8'h9E, 8'h9D, 8'h9B, 8'h7F, 8'h5F};
        exp_o1  = '{8'hCF, 8'hCE, 8'hAF, 8'h8F, 8'h8E, 8'h8D, 8'h8C};

        rst = 1'b1; cfg_we = 1'b0; cfg_ch = 1'b0; cfg_key = 24'h0;
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        drive(1'b1, 1'b0, 8'h00, 1'b0);
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("reset_state", {out0_v, out1_v, unit_rst_n, busy, req0_ready, req1_ready, unit_en, grant_ch},
            8'b0);

        // Single channel frame, cycle by cycle.
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            rst = 1'b0;
            cfg_we = tbl[i].we; cfg_ch = 1'b0; cfg_key = tbl[i].key;
            drive(1'b0, tbl[i].v0, tbl[i].d0, tbl[i].l0);
            #1;
            act = {busy, unit_rst_n, req0_ready, req1_ready, unit_en, unit_din, unit_key,
                   out0_v, out0_data, out1_v, out1_data, grant_ch};
            chk($sformatf("vec%0d", i), act, tbl[i].exp);
        end

        // Contention from the reset-release cycle, then alternation.
        @(negedge clk);
        rst = 1'b1; cfg_we = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        fork
            send_frame(1'b0, 8'h20, 2);
            send_frame(1'b1, 8'h30, 2);
        join
        fork
            send_frame(1'b0, 8'h40, 1);
            send_frame(1'b1, 8'h50, 1);
        join
        wait_idle();

        // Key write mid-frame only lands at the next frame.
        @(negedge clk);
        cfg_we = 1'b1; cfg_ch = 1'b0; cfg_key = 24'hA53C0F;
        @(negedge clk);
        cfg_we = 1'b0;
        fork
            send_frame(1'b0, 8'h60, 3);
            begin
                int w;
                w = 0;
                #1;
                while (!req0_ready && w < 40) begin
                    @(negedge clk);
                    #1;
                    w++;
                end
                @(negedge clk);
                cfg_we = 1'b1; cfg_ch = 1'b0; cfg_key = 24'h112233;
                @(negedge clk);
                cfg_we = 1'b0;
                #1;
                chk("key_mid_frame", unit_key, 24'hA53C0F);
            end
        join
        wait_idle();
        chk("key_idle_hold", unit_key, 24'hA53C0F);
        @(negedge clk);
        send_frame(1'b0, 8'h64, 1);
        #1;
        chk("key_next_frame", unit_key, 24'h112233);
        wait_idle();

        // ch1 stalls for 5 cycles while ch0 requests; nothing moves.
        @(negedge clk);
        send(1'b1, 8'h70, 1'b0);
        send(1'b1, 8'h71, 1'b0);
        drive(1'b1, 1'b0, 8'h00, 1'b0);
        drive(1'b0, 1'b1, 8'hEE, 1'b1);
        for (int k = 0; k < 5; k++) begin
            #1;
            chk($sformatf("stall%0d", k), {unit_en, busy, req1_ready, req0_ready, grant_ch}, 5'b01101);
            @(negedge clk);
        end
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        send(1'b1, 8'h72, 1'b0);
        send(1'b1, 8'h73, 1'b1);
        drive(1'b1, 1'b0, 8'h00, 1'b0);
        wait_idle();

        // Single-byte frame: DRAIN for exactly two cycles.
        @(negedge clk);
        send(1'b0, 8'h80, 1'b1);
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        #1;
        chk("drain1", {busy, req0_ready, unit_en}, 3'b100);
        @(negedge clk);
        #1;
        chk("drain2", {busy, req0_ready, unit_en}, 3'b100);
        @(negedge clk);
        #1;
        chk("drain_done", busy, 1'b0);

        // Reset after 2 bytes of a 6-byte frame.
        @(negedge clk);
        send(1'b0, 8'h90, 1'b0);
        send(1'b0, 8'h91, 1'b0);
        rst = 1'b1;
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        #1;
        chk("rst_unit_held", unit_rst_n, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_idle", {busy, out0_v, out1_v, unit_key, grant_ch}, 28'h0);
        @(negedge clk);
        drive(1'b0, 1'b1, 8'hA0, 1'b1);
        @(negedge clk);
        #1;
        chk("restart_flush", {busy, unit_rst_n, unit_key}, {1'b1, 1'b0, 24'h000000});
        @(negedge clk);
        send(1'b0, 8'hA0, 1'b1);
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        wait_idle();
        repeat (3) @(negedge clk);

        chk("acc_count", acc_log.size(), exp_acc.size());
        for (int i = 0; i < exp_acc.size(); i++)
            if (i < acc_log.size()) chk($sformatf("acc%0d", i), acc_log[i], exp_acc[i]);
        chk("out0_count", o0_log.size(), exp_o0.size());
        for (int i = 0; i < exp_o0.size(); i++)
            if (i < o0_log.size()) chk($sformatf("out0_%0d", i), o0_log[i], exp_o0[i]);
        chk("out1_count", o1_log.size(), exp_o1.size());
        for (int i = 0; i < exp_o1.size(); i++)
            if (i < o1_log.size()) chk($sformatf("out1_%0d", i), o1_log[i], exp_o1[i]);
        chk("both_ready", both_rdy, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
